// File: rtl/great_num_pkg.sv
// Shared types and sizing helpers for the word-serial big-number blocks.
package great_num_pkg;

    localparam int unsigned DEF_REGISTER_SIZE = 32;
    localparam int unsigned DEF_BITS_IN_NUM   = 2048;

    function automatic int unsigned num_packets(input int unsigned bits_in_num,
                                                input int unsigned register_size);
        return bits_in_num / register_size;
    endfunction

    localparam int unsigned DEF_NUM_PACKETS = num_packets(DEF_BITS_IN_NUM, DEF_REGISTER_SIZE);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef logic [$clog2(DEF_NUM_PACKETS):0] pkt_idx_t;

endpackage

// File: rtl/great_word_counter.sv
// Modulo-NUM_PACKETS packet counter with increment, clear and last-word flag.
module great_word_counter
    import great_num_pkg::*;
#(
    parameter int unsigned NUM_PACKETS = DEF_NUM_PACKETS,
    parameter int unsigned CNT_W       = $clog2(NUM_PACKETS) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    input  logic             clr_in,
    output logic [CNT_W-1:0] count_out,
    output logic             is_last_out
);

    logic [CNT_W-1:0] count_q, count_d;

    assign is_last_out = (count_q == CNT_W'(NUM_PACKETS - 1));
    assign count_out   = count_q;

    // Clear wins over increment; increment on the last packet wraps to zero.
    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            count_d = '0;
        end else if (inc_in) begin
            count_d = is_last_out ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/great_collector.sv
// Reassembles a word-serial big-number stream into one parallel number behind valid/ready.
// Optional framing check on final_in enabled by GREAT_COLLECTOR_STREAM_CHECK_EN.
module great_collector
    import great_num_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int unsigned BITS_IN_NUM   = DEF_BITS_IN_NUM
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     carry_in,
    input  logic                     valid_in,
    input  logic                     final_in,
    output logic                     ready_out,
    output logic [BITS_IN_NUM-1:0]   num_out,
    output logic                     overflow_out,
    output logic                     valid_out,
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
    output logic                     error_out,
`endif
    input  logic                     ready_in
);

    localparam int unsigned NUM_PACKETS = num_packets(BITS_IN_NUM, REGISTER_SIZE);
    localparam int unsigned CNT_W       = $clog2(NUM_PACKETS) + 1;

    state_e                 state_q, state_d;
    logic [BITS_IN_NUM-1:0] num_q, num_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       word_idx;
    logic                   is_last;
    logic                   cnt_inc, cnt_clr;
    logic                   accept;

`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
    logic                   err_q, err_d;
`else
    logic                   unused_final;
    assign unused_final = final_in;
`endif

    assign ready_out = (state_q == COLLECT);
    assign accept    = valid_in && ready_out;

    great_word_counter #(
        .NUM_PACKETS (NUM_PACKETS),
        .CNT_W       (CNT_W)
    ) u_word_counter (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .inc_in      (cnt_inc),
        .clr_in      (cnt_clr),
        .count_out   (word_idx),
        .is_last_out (is_last)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    num_d[int'(word_idx) * REGISTER_SIZE +: REGISTER_SIZE] = data_in;
                    cnt_inc = 1'b1;
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
                    // Early final drops the partial number; missing final still completes it.
                    if (final_in && !is_last) begin
                        err_d   = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (is_last) begin
                        ovf_d   = carry_in;
                        valid_d = 1'b1;
                        state_d = HOLD;
                        if (!final_in) begin
                            err_d = 1'b1;
                        end
                    end
`else
                    if (is_last) begin
                        ovf_d   = carry_in;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
`endif
                end
            end
            HOLD: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= COLLECT;
            num_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign num_out      = num_q;
    assign overflow_out = ovf_q;
    assign valid_out    = valid_q;
`ifdef GREAT_COLLECTOR_STREAM_CHECK_EN
    assign error_out    = err_q;
`endif

endmodule
